// File: rtl/knn_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : knn_sequencer_if
// Brief   : Dataset-memory and kNN-unit bus bundle for the kNN sequencer.
// Rev     : 1.0
// ============================================================================
interface knn_sequencer_if #(
    parameter int COORD_W  = 16,
    parameter int CLASS_W  = 3,
    parameter int K_W      = 3,
    parameter int N_COORDS = 2,
    parameter int NP_W     = 10,
    parameter int ADDR_W   = 12
) ();
    logic                         start;
    logic [NP_W-1:0]              nPoints;
    logic [N_COORDS*COORD_W-1:0]  testCoord;
    logic                         dsRe;
    logic [ADDR_W-1:0]            dsAddr;
    logic [COORD_W-1:0]           dsData;
    logic [CLASS_W-1:0]           dsClass;
    logic                         unitClear;
    logic                         valid;
    logic [COORD_W-1:0]           dataPointCoord;
    logic [COORD_W-1:0]           dataSetCoord;
    logic [CLASS_W-1:0]           classIn;
    logic                         incrementClass;
    logic [K_W-1:0]               classIndex;
    logic [CLASS_W-1:0]           classOut;
    logic                         busy;
    logic                         done;
    logic [CLASS_W-1:0]           classResult;

    modport master (
        input  start, nPoints, testCoord, dsData, dsClass, classOut,
        output dsRe, dsAddr, unitClear, valid, dataPointCoord, dataSetCoord,
               classIn, incrementClass, classIndex, busy, done, classResult
    );

    modport slave (
        output start, nPoints, testCoord, dsData, dsClass, classOut,
        input  dsRe, dsAddr, unitClear, valid, dataPointCoord, dataSetCoord,
               classIn, incrementClass, classIndex, busy, done, classResult
    );
endinterface
`default_nettype wire

// File: rtl/knn_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : knn_sequencer
// Brief   : Streams one test point against a dataset into a kNN unit, then
//           runs the vote and captures the winning class.
// Rev     : 1.0
// ============================================================================
module knn_sequencer #(
    parameter int COORD_W      = 16,
    parameter int CLASS_W      = 3,
    parameter int K_W          = 3,
    parameter int K            = 8,
    parameter int N_COORDS     = 2,
    parameter int NP_W         = 10,
    parameter int ADDR_W       = 12,
    parameter int DRAIN_CYCLES = 4
) (
    input  wire             clk,
    input  wire             rst,
    knn_sequencer_if.master bus
);
    localparam int CI_W = (N_COORDS > 1) ? $clog2(N_COORDS) : 1;
    localparam int DC_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_STREAM  = 3'd2,
        S_DRAIN   = 3'd3,
        S_VOTE    = 3'd4,
        S_CAPTURE = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t                              state_q;
    logic [N_COORDS-1:0][COORD_W-1:0]    test_q;
    logic [ADDR_W-1:0]                   addr_q;
    logic [ADDR_W-1:0]                   last_q;
    logic [CI_W-1:0]                     coord_q;
    logic [DC_W-1:0]                     drain_q;
    logic [K_W-1:0]                      vlast_q;
    logic [K_W-1:0]                      cidx_q;
    logic                                dsre_q;
    logic                                valid_q;
    logic                                clr_q;
    logic                                incr_q;
    logic                                done_q;
    logic [COORD_W-1:0]                  dpc_q;
    logic [CLASS_W-1:0]                  res_q;

    logic [ADDR_W-1:0]                   last_d;
    logic [K_W-1:0]                      vlast_d;

    // Last coordinate-word address and last vote index, taken from the start request.
    assign last_d  = ADDR_W'(32'(bus.nPoints) * N_COORDS) - ADDR_W'(1);
    assign vlast_d = (bus.nPoints >= NP_W'(K)) ? K_W'(K - 1)
                                               : K_W'(bus.nPoints - NP_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            test_q  <= '0;
            addr_q  <= '0;
            last_q  <= '0;
            coord_q <= '0;
            drain_q <= '0;
            vlast_q <= '0;
            cidx_q  <= '0;
            dsre_q  <= 1'b0;
            valid_q <= 1'b0;
            clr_q   <= 1'b0;
            incr_q  <= 1'b0;
            done_q  <= 1'b0;
            dpc_q   <= '0;
            res_q   <= '0;
        end else begin
            clr_q   <= 1'b0;
            incr_q  <= 1'b0;
            cidx_q  <= '0;
            done_q  <= 1'b0;
            // Read data returns one cycle after the request, so the stream trails dsRe by one.
            valid_q <= dsre_q;
            dpc_q   <= dsre_q ? test_q[coord_q] : '0;

            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.nPoints != '0) begin
                            test_q  <= bus.testCoord;
                            last_q  <= last_d;
                            vlast_q <= vlast_d;
                            clr_q   <= 1'b1;
                            state_q <= S_CLEAR;
                        end else begin
                            res_q   <= '0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_CLEAR: begin
                    addr_q  <= '0;
                    coord_q <= '0;
                    dsre_q  <= 1'b1;
                    state_q <= S_STREAM;
                end
                S_STREAM: begin
                    if (addr_q == last_q) begin
                        dsre_q  <= 1'b0;
                        addr_q  <= '0;
                        coord_q <= '0;
                        drain_q <= '0;
                        state_q <= S_DRAIN;
                    end else begin
                        addr_q  <= addr_q + 1'b1;
                        coord_q <= (coord_q == CI_W'(N_COORDS - 1)) ? '0 : coord_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DC_W'(DRAIN_CYCLES - 1)) begin
                        incr_q  <= 1'b1;
                        state_q <= S_VOTE;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                S_VOTE: begin
                    if (cidx_q == vlast_q) begin
                        state_q <= S_CAPTURE;
                    end else begin
                        incr_q <= 1'b1;
                        cidx_q <= cidx_q + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    res_q   <= bus.classOut;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.dsRe           = dsre_q;
    assign bus.dsAddr         = addr_q;
    assign bus.unitClear      = clr_q;
    assign bus.valid          = valid_q;
    assign bus.dataPointCoord = dpc_q;
    // Memory data is only forwarded while the stream is valid so idle outputs stay at zero.
    assign bus.dataSetCoord   = valid_q ? bus.dsData  : '0;
    assign bus.classIn        = valid_q ? bus.dsClass : '0;
    assign bus.incrementClass = incr_q;
    assign bus.classIndex     = cidx_q;
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.done           = done_q;
    assign bus.classResult    = res_q;
endmodule
`default_nettype wire

// File: tb/tb_knn_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_knn_sequencer
// Brief   : Randomized transactions checked every cycle against a timeline model
//           of the sequencing rules, plus literal spot checks.
// Rev     : 1.0
// ============================================================================
module tb_knn_sequencer;
    localparam int COORD_W = 16;
    localparam int CLASS_W = 3;
    localparam int K_W     = 3;
    localparam int K       = 8;
    localparam int NC      = 2;
    localparam int NP_W    = 10;
    localparam int ADDR_W  = 12;
    localparam int D       = 4;
    localparam int TCW     = NC * COORD_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    knn_sequencer_if #(.COORD_W(COORD_W), .CLASS_W(CLASS_W), .K_W(K_W), .N_COORDS(NC),
                       .NP_W(NP_W), .ADDR_W(ADDR_W)) bus ();
    knn_sequencer #(.COORD_W(COORD_W), .CLASS_W(CLASS_W), .K_W(K_W), .K(K), .N_COORDS(NC),
                    .NP_W(NP_W), .ADDR_W(ADDR_W), .DRAIN_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .bus(bus));

    knn_sequencer_if #(.COORD_W(COORD_W), .CLASS_W(CLASS_W), .K_W(K_W), .N_COORDS(3),
                       .NP_W(NP_W), .ADDR_W(ADDR_W)) bus3 ();
    knn_sequencer #(.COORD_W(COORD_W), .CLASS_W(CLASS_W), .K_W(K_W), .K(K), .N_COORDS(3),
                    .NP_W(NP_W), .ADDR_W(ADDR_W), .DRAIN_CYCLES(D)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3));
    assign bus3.dsData   = '0;
    assign bus3.dsClass  = '0;
    assign bus3.classOut = '0;

    logic [COORD_W-1:0] mem [0:4095];
    logic [CLASS_W-1:0] cls [0:1023];
    int  n_tests = 0;
    int  n_fail  = 0;
    bit  chk_en  = 1'b0;
    bit  cls_force = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Dataset memory and kNN-unit stand-ins.
    always @(posedge clk) begin
        if (bus.dsRe) begin
            bus.dsData  <= mem[bus.dsAddr];
            bus.dsClass <= cls[bus.dsAddr / NC];
        end else begin
            bus.dsData  <= COORD_W'($urandom);
            bus.dsClass <= CLASS_W'($urandom);
        end
        bus.classOut <= cls_force ? CLASS_W'(5) : CLASS_W'($urandom);
    end

    // Reference: cycle offset since the accepted start, plus the latched request.
    bit                 m_act = 1'b0;
    bit                 m_post_rst = 1'b0;
    int                 m_t, m_td, m_M, m_V;
    logic [TCW-1:0]     m_tc;
    logic [CLASS_W-1:0] m_res;

    always @(posedge clk) begin : model
        if (rst) begin
            m_act      <= 1'b0;
            m_res      <= '0;
            m_post_rst <= 1'b1;
        end else if (m_act) begin
            if (m_t == m_td) m_act <= 1'b0;
            else begin
                if (m_t == m_td - 1 && m_M > 0) m_res <= bus.classOut;
                m_t <= m_t + 1;
            end
        end else if (bus.start) begin
            m_M  <= int'(bus.nPoints) * NC;
            m_V  <= (int'(bus.nPoints) < K) ? int'(bus.nPoints) : K;
            m_tc <= bus.testCoord;
            m_td <= (bus.nPoints == '0) ? 1
                    : int'(bus.nPoints) * NC + 3 + D + ((int'(bus.nPoints) < K) ? int'(bus.nPoints) : K);
            if (bus.nPoints == '0) m_res <= '0;
            m_act      <= 1'b1;
            m_t        <= 1;
            m_post_rst <= 1'b0;
        end
    end

    always @(negedge clk) begin : cmp
        int  idx, b;
        logic e_clr, e_re, e_val, e_inc, e_done, e_busy;
        logic [K_W-1:0] e_ci;
        if (chk_en) begin
            e_clr = 0; e_re = 0; e_val = 0; e_inc = 0; e_done = 0; e_busy = 0; e_ci = '0;
            if (m_act) begin
                b      = m_M + 2 + D;
                e_busy = 1;
                e_clr  = (m_M > 0) && (m_t == 1);
                e_re   = (m_M > 0) && (m_t >= 2) && (m_t < 2 + m_M);
                e_val  = (m_M > 0) && (m_t >= 3) && (m_t < 3 + m_M);
                e_inc  = (m_M > 0) && (m_t >= b) && (m_t < b + m_V);
                e_done = (m_t == m_td);
                if (e_inc) e_ci = K_W'(m_t - b);
            end
            chk("busy", bus.busy, e_busy);
            chk("unitClear", bus.unitClear, e_clr);
            chk("dsRe", bus.dsRe, e_re);
            chk("valid", bus.valid, e_val);
            chk("incrementClass", bus.incrementClass, e_inc);
            chk("classIndex", bus.classIndex, e_ci);
            chk("done", bus.done, e_done);
            chk("classResult", bus.classResult, m_res);
            if (e_re) chk("dsAddr", bus.dsAddr, ADDR_W'(m_t - 2));
            if (e_val) begin
                idx = m_t - 3;
                chk("dataSetCoord", bus.dataSetCoord, mem[idx]);
                chk("classIn", bus.classIn, cls[idx / NC]);
                chk("dataPointCoord", bus.dataPointCoord, m_tc[(idx % NC) * COORD_W +: COORD_W]);
            end
            if (!m_act && m_post_rst) begin
                chk("rst_dsAddr", bus.dsAddr, 0);
                chk("rst_dataSetCoord", bus.dataSetCoord, 0);
                chk("rst_dataPointCoord", bus.dataPointCoord, 0);
                chk("rst_classIn", bus.classIn, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem(input int n);
        for (int i = 0; i < n * NC; i++) mem[i] = COORD_W'($urandom);
        for (int p = 0; p < n; p++) cls[p] = CLASS_W'($urandom);
    endtask

    // Called at posedge+1 with the DUT idle; returns done latency and output tallies.
    task automatic run_txn(input int n, input logic [TCW-1:0] tc, input bit poke,
                           output int lat, output int nre, output int nval,
                           output int ninc, output int nclr, output int ndone);
        int M, V, cyc;
        M = n * NC;
        V = (n < K) ? n : K;
        lat = -1; nre = 0; nval = 0; ninc = 0; nclr = 0; ndone = 0;
        bus.start = 1'b1;
        bus.nPoints = NP_W'(n);
        bus.testCoord = tc;
        step();
        bus.start = 1'b0;
        bus.nPoints = NP_W'($urandom);
        bus.testCoord = TCW'({$urandom, $urandom});
        cyc = 1;
        while (cyc < 3000 && !(lat >= 0 && cyc > lat + 4)) begin
            @(negedge clk);
            if (bus.dsRe) nre++;
            if (bus.valid) nval++;
            if (bus.incrementClass) ninc++;
            if (bus.unitClear) nclr++;
            if (bus.done) begin
                ndone++;
                if (lat < 0) lat = cyc;
            end
            step();
            cyc++;
            bus.start = poke && (cyc >= M + 2) && (cyc <= M + 1 + D + V);
            if (bus.start) bus.nPoints = NP_W'($urandom_range(1, 20));
        end
        bus.start = 1'b0;
        if (lat < 0) chk("done_timeout", 0, 1);
    endtask

    initial begin : main
        int lat, nre, nval, ninc, nclr, ndone, n, vc, gap, done3;
        logic [COORD_W-1:0] exp3 [0:2];
        bus.start = 1'b0; bus.nPoints = '0; bus.testCoord = '0;
        bus3.start = 1'b0; bus3.nPoints = '0; bus3.testCoord = '0;
        rst = 1'b1;
        step(); step();
        // start coinciding with reset must be ignored
        bus.start = 1'b1; bus.nPoints = NP_W'(3);
        step();
        chk_en = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", bus.busy, 0);
        chk("rst_classResult_lit", bus.classResult, 0);
        step();
        rst = 1'b0;
        step();

        fill_mem(3);
        run_txn(3, TCW'(32'hABCD_1234), 1'b0, lat, nre, nval, ninc, nclr, ndone);
        chk("n3_latency", lat, 16);
        chk("n3_dsRe_cycles", nre, 6);
        chk("n3_valid_cycles", nval, 6);
        chk("n3_vote_cycles", ninc, 3);
        chk("n3_clear_cycles", nclr, 1);

        fill_mem(10);
        for (int p = 0; p < 10; p++) cls[p] = (p == 3 || p == 8) ? CLASS_W'(2) : CLASS_W'(5);
        cls_force = 1'b1;
        run_txn(10, TCW'({$urandom}), 1'b0, lat, nre, nval, ninc, nclr, ndone);
        chk("n10_vote_cycles", ninc, 8);
        chk("n10_latency", lat, 35);
        @(negedge clk);
        chk("n10_classResult", bus.classResult, 5);
        cls_force = 1'b0;
        step(); step(); step();
        @(negedge clk);
        chk("n10_classResult_hold", bus.classResult, 5);
        step();

        run_txn(0, TCW'({$urandom}), 1'b0, lat, nre, nval, ninc, nclr, ndone);
        chk("n0_latency", lat, 1);
        chk("n0_dsRe_cycles", nre, 0);
        chk("n0_clear_cycles", nclr, 0);
        chk("n0_classResult", bus.classResult, 0);

        // Reset during the third STREAM cycle
        fill_mem(5);
        bus.start = 1'b1; bus.nPoints = NP_W'(5); bus.testCoord = TCW'({$urandom});
        step();
        bus.start = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_dsRe", bus.dsRe, 0);
        chk("midrst_valid", bus.valid, 0);
        chk("midrst_dsAddr", bus.dsAddr, 0);
        step();
        fill_mem(4);
        run_txn(4, TCW'({$urandom}), 1'b0, lat, nre, nval, ninc, nclr, ndone);
        chk("postrst_latency", lat, 1 + 8 + D + 4 + 2);

        fill_mem(6);
        run_txn(6, TCW'({$urandom}), 1'b1, lat, nre, nval, ninc, nclr, ndone);
        chk("poke_done_pulses", ndone, 1);
        chk("poke_latency", lat, 25);

        for (int i = 0; i < 25; i++) begin
            n = (i % 3 == 0) ? $urandom_range(1, 9) : $urandom_range(0, 30);
            fill_mem(n);
            run_txn(n, TCW'({$urandom}), 1'b0, lat, nre, nval, ninc, nclr, ndone);
            repeat ($urandom_range(0, 3)) step();
        end

        // Three-coordinate instance: coordinate index wraps without gaps
        exp3[0] = 16'h1111; exp3[1] = 16'h2222; exp3[2] = 16'h3333;
        bus3.nPoints = NP_W'(2);
        bus3.testCoord = {exp3[2], exp3[1], exp3[0]};
        bus3.start = 1'b1;
        step();
        bus3.start = 1'b0;
        vc = 0; gap = 0; done3 = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus3.valid) begin
                if (vc < 6) chk("nc3_dataPointCoord", bus3.dataPointCoord, exp3[vc % 3]);
                vc++;
            end else if (vc > 0 && vc < 6) begin
                gap = 1;
            end
            if (bus3.done) done3++;
            step();
        end
        chk("nc3_valid_cycles", vc, 6);
        chk("nc3_valid_gap", gap, 0);
        chk("nc3_done_pulses", done3, 1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/knn_sequencer.md
KNN_SEQUENCER -- requirements
Module: knn_sequencer

Interface
REQ-001 SHALL have parameters (name, default, meaning): COORD_W, 16, coordinate width.
REQ-002 SHALL have parameter CLASS_W, 3, class label width.
REQ-003 SHALL have parameter K_W, 3, width of classIndex.
REQ-004 SHALL have parameter K, 8, neighbour list size of the downstream kNN unit.
REQ-005 SHALL have parameter N_COORDS, 2, coordinates per point.
REQ-006 SHALL have parameter NP_W, 10, width of point count.
REQ-007 SHALL have parameter ADDR_W, 12, dataset coordinate address width.
REQ-008 SHALL have parameter DRAIN_CYCLES, 4, downstream distance pipeline flush cycles, >=1.
REQ-009 SHALL have ports (name, direction, width, meaning), clock and reset first: clk in 1 clock; rst in 1 reset. One clock; reset is synchronous and active-high.
REQ-010 start in 1: begin classification of one test point.
REQ-011 nPoints in NP_W: dataset size, sampled on accepted start.
REQ-012 testCoord in N_COORDS*COORD_W: test point, coordinate c at bits [c*COORD_W +: COORD_W], sampled on accepted start.
REQ-013 dsRe out 1, dsAddr out ADDR_W: dataset memory read request and coordinate-word address.
REQ-014 dsData in COORD_W, dsClass in CLASS_W: read data and class of the addressed point, valid exactly 1 cycle after dsRe.
REQ-015 unitClear out 1: clear pulse to the kNN unit.
REQ-016 valid out 1, dataPointCoord out COORD_W, dataSetCoord out COORD_W, classIn out CLASS_W: coordinate stream to the kNN unit.
REQ-017 incrementClass out 1, classIndex out K_W: vote control to the kNN unit.
REQ-018 classOut in CLASS_W: winning class from the kNN unit.
REQ-019 busy out 1, done out 1, classResult out CLASS_W: status, 1-cycle completion pulse, registered result.

Function
REQ-020 SHALL implement states IDLE, CLEAR, STREAM, DRAIN, VOTE, CAPTURE, DONE.
REQ-021 IDLE: busy=0; start=1 with nPoints>0 -> CLEAR, latching nPoints and testCoord.
REQ-022 IDLE: start=1 with nPoints=0 -> DONE, with classResult set to 0.
REQ-023 start while busy=1 SHALL be ignored.
REQ-024 CLEAR: unitClear=1 for exactly 1 cycle, address counter reset to 0 -> STREAM.
REQ-025 STREAM: dsRe=1 every cycle; dsAddr runs 0..nPoints*N_COORDS-1, +1 per cycle; last issue -> DRAIN.
REQ-026 For each read, valid=1 one cycle after dsRe, with dataSetCoord=dsData, classIn=dsClass, dataPointCoord=latched coordinate (dsAddr mod N_COORDS).
REQ-027 The coordinate index SHALL wrap from N_COORDS-1 to 0 without a bubble; valid SHALL be contiguous for nPoints*N_COORDS cycles.
REQ-028 DRAIN: stay exactly DRAIN_CYCLES cycles, counted from the cycle after the last dsRe -> VOTE.
REQ-029 VOTE: incrementClass=1 for V=min(K, nPoints) consecutive cycles, classIndex=0..V-1.
REQ-030 classIndex SHALL be 0 whenever incrementClass=0.
REQ-031 CAPTURE: 1 cycle, no kNN outputs asserted; classResult <= classOut at the end of the cycle -> DONE.
REQ-032 DONE: done=1 for 1 cycle -> IDLE.
REQ-033 classResult SHALL hold until the next DONE.
REQ-034 busy=1 in every state except IDLE.
REQ-035 Latency from accepted start to done=1 SHALL be 1+nPoints*N_COORDS+DRAIN_CYCLES+V+1+1 cycles (start cycle = 0); 1 cycle for nPoints=0.
REQ-036 Address arithmetic SHALL be ADDR_W bits; behaviour for nPoints*N_COORDS > 2**ADDR_W is undefined.
REQ-037 valid, dsRe, unitClear and incrementClass SHALL never be high in the same cycle, except valid with dsRe during STREAM.

Reset
REQ-038 rst=1 SHALL force IDLE in any state, including mid-STREAM or mid-VOTE.
REQ-039 rst=1 SHALL drive all outputs to 0, including classResult, dsAddr and classIndex, on the next edge.
REQ-040 A start asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-041 nPoints=3, N_COORDS=2, DRAIN_CYCLES=4, K=8 -> dsAddr 0..5 on consecutive cycles; 6 contiguous valid cycles; incrementClass for 3 cycles; done at cycle 1+6+4+3+2=16.
REQ-042 nPoints=10, classes {5,5,5,2,...}, memory model returns 5 for the nearest 8 -> exactly 8 vote cycles (classIndex 0..7); classResult=5 and stable after done.
REQ-043 start with nPoints=0 -> done=1 on the next cycle, classResult=0, dsRe and unitClear never asserted.
REQ-044 rst pulsed at the 3rd STREAM cycle -> next cycle busy=0 and all outputs 0; a following start runs a complete, correct sequence.
REQ-045 start re-asserted during DRAIN and VOTE -> ignored; exactly one done pulse is produced.
REQ-046 N_COORDS=3, nPoints=2 -> dataPointCoord cycles testCoord[0],[1],[2],[0],[1],[2] with no gaps in valid.
